// File: rtl/divby_pkg.sv
// Shared helpers for the serial divisibility checker: width helper, Gray
// conversion and bit-order mode encodings.
package divby_pkg;

  // Bit-order modes for the LSB_FIRST parameter.
  localparam int unsigned MODE_MSB = 0;
  localparam int unsigned MODE_LSB = 1;

  // Widest remainder the block supports (N <= 256 needs 8 bits) plus one.
  localparam int unsigned MaxW = 9;

  // $clog2 that never returns 0, so a 1-bit register is always legal.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Callers zero-extend to MaxW and truncate back; leading zeros are
  // transparent to both conversions.
  function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] g);
    logic [MaxW-1:0] b;
    b[MaxW-1] = g[MaxW-1];
    for (int i = MaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/divby_mod_step.sv
// One combinational step of the running residue: consumes one bit and
// returns the next remainder and next LSB-first weight, all modulo N.
module divby_mod_step
  import divby_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned RW        = clog2_safe(N),
  parameter int unsigned LSB_FIRST = MODE_MSB
) (
  input  logic [RW-1:0] r,
  input  logic          b,
  input  logic [RW-1:0] w,
  output logic [RW-1:0] r_nxt,
  output logic [RW-1:0] w_nxt
);

  // N <= 2^RW, so N always fits in RW+1 bits.
  localparam logic [RW:0] NMod = (RW + 1)'(N);

  logic [RW-1:0] addend;
  logic [RW:0]   r_sum;
  logic [RW:0]   w_sum;

  // Both operands are residues (< N), so every sum is < 2N and one
  // conditional subtract brings it back into range.
  always_comb begin
    addend = b ? w : '0;
    if (LSB_FIRST == MODE_LSB) begin
      r_sum = {1'b0, r} + {1'b0, addend};
    end else begin
      r_sum = {r, b};
    end
    w_sum = {w, 1'b0};
    r_nxt = (r_sum >= NMod) ? RW'(r_sum - NMod) : r_sum[RW-1:0];
    w_nxt = (w_sum >= NMod) ? RW'(w_sum - NMod) : w_sum[RW-1:0];
  end

endmodule

// File: rtl/divby_n_serial.sv
// Serial divisibility checker: tracks the running value of a bit stream
// modulo N and flags when it is divisible. Optional build macro
// DIVBYN_GRAY_STATE_EN stores the remainder register Gray-coded; the
// visible rem/div_ok/rem_valid/out_strobe behaviour is identical either way.
module divby_n_serial
  import divby_pkg::*;
#(
  parameter int unsigned N         = 3,
  parameter int unsigned RW        = clog2_safe(N),
  parameter int unsigned LSB_FIRST = MODE_MSB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_bit,
  input  logic          in_clear,
  output logic [RW-1:0] rem,
  output logic          div_ok,
  output logic          rem_valid,
  output logic          out_strobe,
  output logic [RW-1:0] state_dbg
);

  if (N < 2 || N > 256) begin : g_bad_n
    $error("divby_n_serial: N must be in 2..256");
  end
  if (RW != clog2_safe(N)) begin : g_bad_rw
    $error("divby_n_serial: RW is derived from N and must not be overridden");
  end

  // Weight of the first bit in LSB-first mode is 2^0 = 1 (N >= 2).
  localparam logic [RW-1:0] WOne = RW'(1);

  logic [RW-1:0] state_q, state_d;
  logic [RW-1:0] w_q, w_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;

  logic [RW-1:0] rem_bin;
  logic [RW-1:0] base_r, base_w;
  logic [RW-1:0] step_r, step_w;
  logic [RW-1:0] step_enc;

`ifdef DIVBYN_GRAY_STATE_EN
  assign rem_bin  = RW'(gray2bin(MaxW'(state_q)));
  assign step_enc = RW'(bin2gray(MaxW'(step_r)));
`else
  assign rem_bin  = state_q;
  assign step_enc = step_r;
`endif

  divby_mod_step #(
    .N         (N),
    .RW        (RW),
    .LSB_FIRST (LSB_FIRST)
  ) u_step (
    .r     (base_r),
    .b     (in_bit),
    .w     (base_w),
    .r_nxt (step_r),
    .w_nxt (step_w)
  );

  // Next state: clear first restarts the number, then an accepted bit steps it.
  always_comb begin
    base_r   = in_clear ? '0 : rem_bin;
    base_w   = in_clear ? WOne : w_q;
    state_d  = state_q;
    w_d      = w_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    if (in_valid) begin
      state_d  = step_enc;
      w_d      = step_w;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
    end else if (in_clear) begin
      state_d = '0;
      w_d     = WOne;
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; Gray(0) is 0 so reset is build-independent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= '0;
      w_q      <= WOne;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign rem        = rem_bin;
  assign div_ok     = (rem_bin == '0);
  assign rem_valid  = valid_q;
  assign out_strobe = strobe_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_divby_n_serial.sv
// Self-checking bench: five checker instances (N=3 MSB, N=5 MSB, N=3 LSB,
// N=7 MSB, N=256 MSB) share one stimulus stream; a scoreboard queue holds
// the expected post-edge outputs computed from full-precision values.
module tb_divby_n_serial;

  localparam int unsigned NumDut = 5;
  localparam int unsigned NS [NumDut] = '{3, 5, 3, 7, 256};
  localparam bit          LS [NumDut] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic clk;
  logic rst;
  logic in_valid;
  logic in_bit;
  logic in_clear;

  logic [1:0] rem_a, dbg_a;
  logic [2:0] rem_b, dbg_b;
  logic [1:0] rem_c, dbg_c;
  logic [2:0] rem_d, dbg_d;
  logic [7:0] rem_e, dbg_e;
  logic [NumDut-1:0] ok_v, val_v, stb_v;

  divby_n_serial #(.N(3), .LSB_FIRST(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_clear(in_clear),
    .rem(rem_a), .div_ok(ok_v[0]), .rem_valid(val_v[0]), .out_strobe(stb_v[0]),
    .state_dbg(dbg_a)
  );
  divby_n_serial #(.N(5), .LSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_clear(in_clear),
    .rem(rem_b), .div_ok(ok_v[1]), .rem_valid(val_v[1]), .out_strobe(stb_v[1]),
    .state_dbg(dbg_b)
  );
  divby_n_serial #(.N(3), .LSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_clear(in_clear),
    .rem(rem_c), .div_ok(ok_v[2]), .rem_valid(val_v[2]), .out_strobe(stb_v[2]),
    .state_dbg(dbg_c)
  );
  divby_n_serial #(.N(7), .LSB_FIRST(0)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_clear(in_clear),
    .rem(rem_d), .div_ok(ok_v[3]), .rem_valid(val_v[3]), .out_strobe(stb_v[3]),
    .state_dbg(dbg_d)
  );
  divby_n_serial #(.N(256), .LSB_FIRST(0)) u_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .in_clear(in_clear),
    .rem(rem_e), .div_ok(ok_v[4]), .rem_valid(val_v[4]), .out_strobe(stb_v[4]),
    .state_dbg(dbg_e)
  );

  int unsigned got_rem [NumDut];
  int unsigned got_dbg [NumDut];
  always_comb begin
    got_rem[0] = 32'(rem_a);  got_dbg[0] = 32'(dbg_a);
    got_rem[1] = 32'(rem_b);  got_dbg[1] = 32'(dbg_b);
    got_rem[2] = 32'(rem_c);  got_dbg[2] = 32'(dbg_c);
    got_rem[3] = 32'(rem_d);  got_dbg[3] = 32'(dbg_d);
    got_rem[4] = 32'(rem_e);  got_dbg[4] = 32'(dbg_e);
  end

  typedef struct {
    int unsigned rem [NumDut];
    bit          valid;
    bit          strobe;
  } exp_t;

  exp_t sb [$];

  // Reference model: exact value of the current number (streams stay < 60 bits).
  longint unsigned mval [NumDut];
  int unsigned     mpos;
  bit              mvalid;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive one cycle, push the expected post-edge outputs, then pop and compare.
  task automatic drive(input bit v, input bit b, input bit c, input bit r);
    exp_t e;
    exp_t o;
    int unsigned er;
    int unsigned ed;
    in_valid = v;
    in_bit   = v ? b : 1'bx;
    in_clear = c;
    rst      = r;
    if (r) begin
      for (int i = 0; i < NumDut; i++) mval[i] = 0;
      mpos = 0; mvalid = 1'b0; e.strobe = 1'b0;
    end else begin
      if (c) begin
        for (int i = 0; i < NumDut; i++) mval[i] = 0;
        mpos = 0; mvalid = 1'b0;
      end
      if (v) begin
        for (int i = 0; i < NumDut; i++) begin
          if (LS[i]) mval[i] = mval[i] + (longint'(b) << mpos);
          else       mval[i] = mval[i] * 2 + longint'(b);
        end
        mpos++; mvalid = 1'b1;
      end
      e.strobe = v;
    end
    e.valid = mvalid;
    for (int i = 0; i < NumDut; i++) e.rem[i] = int'(mval[i] % longint'(NS[i]));
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      o = sb.pop_front();
      for (int i = 0; i < NumDut; i++) begin
        er = o.rem[i];
`ifdef DIVBYN_GRAY_STATE_EN
        ed = er ^ (er >> 1);
`else
        ed = er;
`endif
        check($sformatf("d%0d_rem", i), got_rem[i], er);
        check($sformatf("d%0d_div_ok", i), 32'(ok_v[i]), 32'(er == 0));
        check($sformatf("d%0d_state_dbg", i), got_dbg[i], ed);
        check($sformatf("d%0d_rem_valid", i), 32'(val_v[i]), 32'(o.valid));
        check($sformatf("d%0d_out_strobe", i), 32'(stb_v[i]), 32'(o.strobe));
      end
    end
  endtask

  initial begin
    bit v;
    bit b;
    bit c;
    in_valid = 1'b0; in_bit = 1'bx; in_clear = 1'b0; rst = 1'b1;
    mpos = 0; mvalid = 1'b0;
    for (int i = 0; i < NumDut; i++) mval[i] = 0;

    // Reset state.
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    check("rst_rem_n3", got_rem[0], 0);
    check("rst_div_ok", 32'(ok_v[0]), 1);
    check("rst_rem_valid", 32'(val_v[0]), 0);

    // 6 MSB-first: N=3 gives 1,0,0.
    drive(1, 1, 1, 0);
    check("t1_rem_n3_b0", got_rem[0], 1);
    check("t1_valid_b0", 32'(val_v[0]), 1);
    drive(1, 1, 0, 0);
    check("t1_rem_n3_b1", got_rem[0], 0);
    drive(1, 0, 0, 0);
    check("t1_rem_n3_b2", got_rem[0], 0);
    check("t1_div_ok_n3", 32'(ok_v[0]), 1);

    // Clear without a bit.
    drive(0, 0, 1, 0);
    check("clr_valid", 32'(val_v[0]), 0);

    // 7 MSB-first: N=5 gives 1,3,2 and holds while idle.
    drive(1, 1, 1, 0);
    drive(1, 1, 0, 0);
    check("t2_rem_n5_b1", got_rem[1], 3);
    drive(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) drive(0, 0, 0, 0);
    check("t2_rem_n5_held", got_rem[1], 2);
    check("t2_strobe_idle", 32'(stb_v[1]), 0);

    // 5 LSB-first (1,0,1): N=3 LSB gives 1,1,2.
    drive(1, 1, 1, 0);
    drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    check("t3_rem_n3_lsb", got_rem[2], 2);

    // 168 = 7*24 with clear+valid on the first bit.
    drive(1, 1, 1, 0);
    drive(1, 0, 0, 0); drive(1, 1, 0, 0); drive(1, 0, 0, 0);
    drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    check("t4_rem_n7", got_rem[3], 0);
    check("t4_div_ok_n7", 32'(ok_v[3]), 1);

    // Nine ones for N=256.
    drive(0, 0, 1, 0);
    for (int k = 0; k < 8; k++) drive(1, 1, 0, 0);
    check("t5_rem_n256_8", got_rem[4], 255);
    drive(1, 1, 0, 0);
    check("t5_rem_n256_9", got_rem[4], 255);

    // Mid-stream reset overrides an accepted bit.
    drive(1, 1, 1, 0);
    drive(1, 1, 0, 0);
    drive(1, 1, 0, 1);
    check("t6_rst_rem", got_rem[0], 0);
    check("t6_rst_strobe", 32'(stb_v[0]), 0);
    drive(1, 1, 0, 0);
    check("t6_after_rem", got_rem[0], 1);

    // Random mix of idle, clear and bits, kept under 40 bits per number.
    drive(0, 0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      v = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 7) == 0);
      drive(v, b, c, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
